// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: per-button FSM states,
// board button indices and the counter sizing helper.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } btn_state_e;

  localparam int BTN_LEFT    = 0;
  localparam int BTN_RIGHT   = 1;
  localparam int BTN_UP      = 2;
  localparam int BTN_DOWN    = 3;
  localparam int BTN_CONFIRM = 4;

  // The counter only ever needs to reach (largest ms parameter - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One conditioned button: debounce FSM with a shared tick-based counter,
// registered level and single-cycle press/release pulses, optional auto-repeat.
module btn_debounce_fsm
  import button_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 150
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic s_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = cnt_width(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY_MS - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE_MS - 1);

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick_i) begin
      case (state_q)
        IDLE: if (s_i) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
        PRESS_DB: begin
          if (!s_i)                  state_d = IDLE;
          else if (cnt_q == DB_LAST) begin state_d = HELD; cnt_d = '0; end
          else                       cnt_d = cnt_q + CW'(1);
        end
        // Without repeat_en the counter parks at RD_LAST, so enabling later repeats at once.
        HELD: begin
          if (!s_i) begin
            state_d = REL_DB;
            cnt_d   = '0;
          end else if (cnt_q == RD_LAST) begin
            if (repeat_en_i) begin state_d = REPEAT; cnt_d = '0; end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        REPEAT: begin
          if (!s_i)                  begin state_d = REL_DB; cnt_d = '0; end
          else if (cnt_q == RR_LAST) cnt_d = '0;
          else                       cnt_d = cnt_q + CW'(1);
        end
        REL_DB: begin
          if (s_i)                   begin state_d = HELD; cnt_d = '0; end
          else if (cnt_q == DB_LAST) state_d = IDLE;
          else                       cnt_d = cnt_q + CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    level_d   = level_q;
    if (tick_i) begin
      case (state_q)
        PRESS_DB: if (s_i && cnt_q == DB_LAST) begin
          press_d = 1'b1;
          level_d = 1'b1;
        end
        HELD:     if (s_i && repeat_en_i && cnt_q == RD_LAST) press_d = 1'b1;
        REPEAT:   if (s_i && repeat_en_i && cnt_q == RR_LAST) press_d = 1'b1;
        REL_DB:   if (!s_i && cnt_q == DB_LAST) begin
          release_d = 1'b1;
          level_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Board push-button front end: 2-flop synchronisers, a shared ms tick divider
// and one debounce FSM per button.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int TICK_DIV        = 100000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 150
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int TW = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [N_BTN-1:0] sync1_q, sync2_q;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS)
    ) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .tick_i     (tick),
      .s_i        (sync2_q[i]),
      .repeat_en_i(repeat_en[i]),
      .level_o    (btn_level[i]),
      .press_o    (btn_press[i]),
      .release_o  (btn_release[i])
    );
  end

endmodule
